mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//   Memory-mapped I/O responder on the EX-stage data-memory port. The EX stage issues
//   load/store address, store data and byte-write enables; DMEM serves 0x0xxx_xxxx,
//   and this block serves the I/O window.
//   Provides a UART TX FIFO, an RX holding register and cycle/instruction counters.
//   Read data returns one cycle later, aligned with DMEM, for the MWB-stage writeback mux.
// PARAMETERS
//   TX_DEPTH   8             TX FIFO entries; power of 2, >=2
//   IO_BASE    4'h8          io_addr[31:28] value that selects this block
//   CNT_WIDTH  32            counter width, <=32; zero-extended on read
// PORTS
//   clk            in   1   system clock
//   rst            in   1   asynchronous reset, active-high
//   io_addr        in   32  byte address (EX ALU result)
//   io_wdata       in   32  store data, already lane-aligned by the store path
//   io_wea         in   4   byte write enables; store when != 0
//   io_re          in   1   load request this cycle
//   instr_retire   in   1   valid (non-bubble) instruction leaving MWB this cycle
//   io_rdata       out  32  registered load data, valid the cycle after io_re
//   uart_tx_data   out  8   byte to UART transmitter (FIFO head)
//   uart_tx_valid  out  1   FIFO non-empty
//   uart_tx_ready  in   1   transmitter accepts byte when valid&ready
//   uart_rx_data   in   8   byte from UART receiver
//   uart_rx_valid  in   1   receiver byte available
//   uart_rx_ready  out  1   = !rx_full
// BEHAVIOUR
//   Select: sel = (io_addr[31:28]==IO_BASE). Offset = io_addr[7:0]. Accesses with sel=0 are ignored.
//   Register map (offset):
//     0x00 RO status: bit0 = !tx_full, bit1 = rx_full, other bits 0
//     0x04 RO rx data {24'b0,rx_buf}; a read with rx_full=1 pops (rx_full<=0 at that edge)
//     0x08 WO tx data: io_wdata[7:0] pushed when io_wea[0]=1
//     0x10 RO cycle_cnt; 0x14 RO instr_cnt; 0x18 WO any store clears both counters
//     Unmapped offsets: read 0, writes ignored. Writes to RO offsets are ignored.
//   Reads: io_rdata <= sel&io_re ? mapped value : 32'b0; value sampled before the edge.
//     Latency is exactly 1 cycle. Empty rx read returns 0 and does not pop.
//   TX FIFO: pop on uart_tx_valid&uart_tx_ready. Push accepted when count<TX_DEPTH, or when
//     full with a pop in the same cycle (count unchanged). Otherwise the push is dropped
//     silently; software polls status bit0. Read/write pointers wrap modulo TX_DEPTH.
//     Count ranges 0..TX_DEPTH. uart_tx_data = mem[rd_ptr] and is stable while valid&!ready.
//   RX: when uart_rx_valid&uart_rx_ready: rx_buf<=uart_rx_data, rx_full<=1. A pop and a capture
//     cannot coincide because ready=0 while full.
//   Counters: cycle_cnt +1 every cycle; instr_cnt +1 when instr_retire. Both wrap at 2^CNT_WIDTH.
//     A clear store beats increment: the value after the edge is 0, and counting resumes next cycle.
//   Simultaneous io_re and io_wea: the read returns pre-edge state and the write also takes effect.
//   Reset (async, any time incl. mid-transfer): io_rdata=0, FIFO empty (uart_tx_valid=0),
//     rx_full=0 (uart_rx_ready=1), rx_buf=0, both counters 0. A TX byte in flight is discarded.
// TESTING
//   1 Reset, then read 0x00,0x04,0x10 -> status=32'h1, rx=0, cycle_cnt equals cycles since reset release.
//   2 tx_ready=0; store 0x41..0x48 to 0x80000008, then a 9th store 0x49 -> status bit0=0; set
//     ready=1 -> bytes 0x41..0x48 emitted in order, 0x49 never appears.
//   3 FIFO full, store 0x55 with tx_ready=1 on the same cycle -> push accepted, count stays 8,
//     0x55 emitted last.
//   4 rx_valid with byte 0x5A -> rx_ready=0, status=32'h3; read 0x04 -> io_rdata=32'h5A next
//     cycle, rx_ready=1. Second read of 0x04 -> 0.
//   5 Retire 10 instrs, store to 0x18 while instr_retire=1 -> 0x14 reads 0 the next cycle, then 1.
//   6 Assert rst with FIFO holding 3 bytes and tx_valid=1 -> tx_valid=0 immediately (async);
//     after release, status=32'h1.

Source files
------------

// File: rtl/mmio_responder.sv
// MMIO responder for the I/O window of the EX-stage data port: UART TX FIFO,
// RX holding register and cycle/instruction counters, with 1-cycle read latency.
module mmio_responder #(
  parameter int         TX_DEPTH  = 8,
  parameter logic [3:0] IO_BASE   = 4'h8,
  parameter int         CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wea,
  input  logic        io_re,
  input  logic        instr_retire,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int        PW       = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TX_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INS    = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] off;
  } req_t;

  req_t req;
  assign req.rd  = (io_addr[31:28] == IO_BASE) & io_re;
  assign req.wr  = (io_addr[31:28] == IO_BASE) & (|io_wea);
  assign req.off = io_addr[7:0];

  logic unused_bits;
  assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

  // TX FIFO
  logic [7:0]    mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   tx_cnt;
  logic          tx_full, tx_pop, tx_push;

  assign tx_full       = (tx_cnt == FULL_CNT);
  assign uart_tx_valid = (tx_cnt != '0);
  assign uart_tx_data  = mem[rd_ptr];
  assign tx_pop        = uart_tx_valid & uart_tx_ready;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign tx_push       = req.wr & (req.off == OFF_TX) & io_wea[0] & (~tx_full | tx_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) mem[wr_ptr] <= io_wdata[7:0];
  end

  // RX holding register
  logic       rx_full, rx_pop, rx_cap;
  logic [7:0] rx_buf;

  assign uart_rx_ready = ~rx_full;
  assign rx_cap        = uart_rx_valid & uart_rx_ready;
  assign rx_pop        = req.rd & (req.off == OFF_RX) & rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_buf  <= '0;
    end else if (rx_cap) begin
      rx_full <= 1'b1;
      rx_buf  <= uart_rx_data;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  // Counters; a clear store wins over the increment on the same edge.
  logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
  logic                 cnt_clr;

  assign cnt_clr = req.wr & (req.off == OFF_CLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Read path
  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    if (req.rd) begin
      case (req.off)
        OFF_STATUS: rd_next = {30'b0, rx_full, ~tx_full};
        OFF_RX:     rd_next = rx_full ? {24'b0, rx_buf} : 32'b0;
        OFF_CYC:    rd_next = 32'(cycle_cnt);
        OFF_INS:    rd_next = 32'(instr_cnt);
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) io_rdata <= '0;
    else     io_rdata <= rd_next;
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed table, corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_mmio_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_addr = '0, io_wdata = '0;
  logic [3:0]  io_wea = '0;
  logic        io_re = 1'b0, instr_retire = 1'b0;
  logic [31:0] io_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0, uart_rx_ready;

  mmio_responder #(.TX_DEPTH(8), .IO_BASE(4'h8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_wdata(io_wdata), .io_wea(io_wea),
    .io_re(io_re), .instr_retire(instr_retire), .io_rdata(io_rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: FIFO as a queue, registers as plain variables.
  logic [7:0]  mq[$];
  logic        m_rxf = 1'b0;
  logic [7:0]  m_rxb = '0;
  logic [31:0] m_cyc = '0, m_ins = '0, m_rd = '0;
  int          m_n;
  bit          m_pop, m_sel, m_cap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rxf = 1'b0; m_rxb = '0; m_cyc = '0; m_ins = '0; m_rd = '0;
    end else begin
      m_n   = mq.size();
      m_sel = (io_addr[31:28] == 4'h8);
      m_pop = (m_n > 0) && uart_tx_ready;
      m_cap = uart_rx_valid && !m_rxf;
      m_rd  = 32'h0;
      if (m_sel && io_re)
        case (io_addr[7:0])
          8'h00: m_rd = {30'b0, m_rxf, (m_n < 8)};
          8'h04: m_rd = m_rxf ? {24'b0, m_rxb} : 32'h0;
          8'h10: m_rd = m_cyc;
          8'h14: m_rd = m_ins;
          default: m_rd = 32'h0;
        endcase
      if (m_sel && io_re && io_addr[7:0] == 8'h04 && m_rxf) m_rxf = 1'b0;
      if (m_cap) begin m_rxf = 1'b1; m_rxb = uart_rx_data; end
      if (m_pop) void'(mq.pop_front());
      if (m_sel && io_addr[7:0] == 8'h08 && io_wea[0] && (m_n < 8 || m_pop))
        mq.push_back(io_wdata[7:0]);
      if (m_sel && io_addr[7:0] == 8'h18 && io_wea != 4'h0) begin
        m_cyc = '0; m_ins = '0;
      end else begin
        m_cyc = m_cyc + 1;
        if (instr_retire) m_ins = m_ins + 1;
      end
    end
  end

  // Bytes actually handed to the transmitter by the DUT.
  logic [7:0] dut_tx[$];
  always @(negedge clk)
    if (!rst && uart_tx_valid && uart_tx_ready) dut_tx.push_back(uart_tx_data);

  task automatic tick();
    @(posedge clk); #1;
    if (!rst) begin
      chk("model_rdata", io_rdata, m_rd);
      chk("model_tx_valid", {31'b0, uart_tx_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) chk("model_tx_data", {24'b0, uart_tx_data}, {24'b0, mq[0]});
      chk("model_rx_ready", {31'b0, uart_rx_ready}, {31'b0, !m_rxf});
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic re);
    io_addr = a; io_wdata = d; io_wea = we; io_re = re;
  endtask

  task automatic bus_idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    drive(a, 32'h0, 4'h0, 1'b1); tick(); v = io_rdata; bus_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 4'h1, 1'b0); tick(); bus_idle();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic        re;
    logic [31:0] exp_rd;
    logic        exp_txv;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] addrs[8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0010,
                            32'h8000_0014, 32'h8000_0018, 32'h8000_000C, 32'h0000_0008};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    tbl[0] = '{32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1, 1'b0};
    tbl[1] = '{32'h8000_0004, 32'h0,         4'h0, 1'b1, 32'h0, 1'b0};
    tbl[2] = '{32'h8000_0020, 32'h0,         4'h0, 1'b1, 32'h0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h1, 1'b0};
    tbl[4] = '{32'h9000_0000, 32'h0,         4'h0, 1'b1, 32'h0, 1'b0};
    tbl[5] = '{32'h8000_0008, 32'hAB,        4'h2, 1'b1, 32'h0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1, 1'b0};
    tbl[7] = '{32'h8000_0008, 32'h11,        4'h1, 1'b0, 32'h0, 1'b1};
    tbl[8] = '{32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1, 1'b1};
    tbl[9] = '{32'h0000_0008, 32'h22,        4'h1, 1'b1, 32'h0, 1'b1};

    // Reset state and cycle counter origin
    rst = 1'b1; tick(); tick();
    chk("reset_rdata", io_rdata, 32'h0);
    chk("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    rst = 1'b0;
    tick(); tick(); tick();
    rd(32'h8000_0010, v); chk("cycle_since_reset", v, 32'd3);
    rd(32'h8000_0000, v); chk("status_after_reset", v, 32'h1);
    rd(32'h8000_0004, v); chk("rx_after_reset", v, 32'h0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].addr, tbl[i].wdata, tbl[i].wea, tbl[i].re);
      tick();
      chk($sformatf("tbl%0d_rdata", i), io_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_txv", i), {31'b0, uart_tx_valid}, {31'b0, tbl[i].exp_txv});
    end
    bus_idle();
    uart_tx_ready = 1'b1; tick(); tick(); uart_tx_ready = 1'b0;
    chk("tbl_drain_one", dut_tx.size(), 32'd1);
    dut_tx.delete();

    // FIFO overflow drops the extra byte
    for (int i = 0; i < 9; i++) wr(32'h8000_0008, 32'h41 + i);
    rd(32'h8000_0000, v); chk("status_tx_full", v, 32'h0);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    uart_tx_ready = 1'b0;
    chk("overflow_count", dut_tx.size(), 32'd8);
    for (int i = 0; i < 8 && i < dut_tx.size(); i++)
      chk($sformatf("overflow_byte%0d", i), {24'b0, dut_tx[i]}, 32'h41 + i);
    dut_tx.delete();

    // Push into a full FIFO together with a pop
    for (int i = 0; i < 8; i++) wr(32'h8000_0008, 32'h60 + i);
    uart_tx_ready = 1'b1; wr(32'h8000_0008, 32'h55); uart_tx_ready = 1'b0;
    rd(32'h8000_0000, v); chk("full_push_pop_status", v, 32'h0);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    uart_tx_ready = 1'b0;
    chk("push_pop_count", dut_tx.size(), 32'd9);
    if (dut_tx.size() == 9) begin
      for (int i = 0; i < 8; i++) chk($sformatf("push_pop_byte%0d", i), {24'b0, dut_tx[i]}, 32'h60 + i);
      chk("push_pop_last", {24'b0, dut_tx[8]}, 32'h55);
    end
    dut_tx.delete();

    // RX capture, pop, empty read
    uart_rx_data = 8'h5A; uart_rx_valid = 1'b1; tick();
    uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    chk("rx_ready_full", {31'b0, uart_rx_ready}, 32'h0);
    rd(32'h8000_0000, v); chk("status_rx_full", v, 32'h3);
    rd(32'h8000_0004, v); chk("rx_data", v, 32'h5A);
    chk("rx_ready_after_pop", {31'b0, uart_rx_ready}, 32'h1);
    rd(32'h8000_0004, v); chk("rx_empty_read", v, 32'h0);

    // Counter clear beats retire increment
    wr(32'h8000_0018, 32'h0);
    instr_retire = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    instr_retire = 1'b0;
    rd(32'h8000_0014, v); chk("instr_cnt_10", v, 32'd10);
    instr_retire = 1'b1;
    wr(32'h8000_0018, 32'h0);
    rd(32'h8000_0014, v); chk("instr_after_clear", v, 32'd0);
    instr_retire = 1'b0;
    rd(32'h8000_0014, v); chk("instr_resume", v, 32'd1);

    // Async reset with bytes in the FIFO
    for (int i = 0; i < 3; i++) wr(32'h8000_0008, 32'h70 + i);
    chk("pre_reset_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
    #2 rst = 1'b1; #1;
    chk("async_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("async_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    chk("async_rdata", io_rdata, 32'h0);
    tick(); rst = 1'b0;
    rd(32'h8000_0000, v); chk("status_after_async", v, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(addrs[$urandom_range(0, 7)], $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
      if (io_addr[7:0] == 8'h18 && $urandom_range(0, 3) != 0) io_wea = 4'h0;
      uart_tx_ready = 1'($urandom);
      uart_rx_valid = ($urandom_range(0, 2) == 0);
      uart_rx_data  = 8'($urandom);
      instr_retire  = 1'($urandom);
      tick();
    end
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
